btb_sa_array: RTL and testbench

- Set-associative branch target buffer storage that replaces the direct-mapped target array in the fetch-stage predictor.
- Stores tag, valid and target per way, and picks victims with tree pseudo-LRU.
- Forwards same-cycle updates to the lookup port.
- Provides a multi-cycle flush sequencer for fence/context-switch invalidation.

---
 rtl/btb_sa_array.sv | 231 +++++++++++++++++++++++
 tb/tb_btb_sa_array.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_sa_array.sv
// Set-associative branch target buffer storage with tree pseudo-LRU replacement,
// same-cycle update-to-lookup forwarding and a one-set-per-cycle flush sequencer.
module btb_sa_array #(
   parameter int tag_width    = 24,
   parameter int target_width = 32,
   parameter int bit_set      = 4,
   parameter int num_way      = 2,
   localparam int way_w       = (num_way > 1) ? $clog2(num_way) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    lkp_en,
   input  logic [bit_set-1:0]      lkp_index,
   input  logic [tag_width-1:0]    lkp_tag,
   output logic                    lkp_hit,
   output logic [way_w-1:0]        lkp_way,
   output logic [target_width-1:0] lkp_target,
   input  logic                    upd_valid,
   input  logic [bit_set-1:0]      upd_index,
   input  logic [tag_width-1:0]    upd_tag,
   input  logic [target_width-1:0] upd_target,
   input  logic                    flush,
   output logic                    busy
);

   localparam int num_set = 1 << bit_set;
   localparam int lvls    = (num_way > 1) ? $clog2(num_way) : 0;
   localparam int plru_w  = (num_way > 1) ? num_way - 1 : 1;

   typedef enum logic {
      ST_IDLE,
      ST_FLUSH
   } state_t;

   // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
   function automatic logic [plru_w-1:0] plru_touch(input logic [plru_w-1:0] p,
                                                    input logic [way_w-1:0]  w);
      logic [plru_w-1:0] r;
      logic [way_w-1:0]  ws;
      int                n;
      r  = p;
      ws = w;
      n  = 0;
      for (int l = 0; l < lvls; l++) begin
         ws = w >> (lvls - 1 - l);
         r  = (r & ~(plru_w'(1) << n)) | (plru_w'(~ws[0]) << n);
         n  = 2 * n + 1 + int'(ws[0]);
      end
      return r;
   endfunction

   function automatic logic [way_w-1:0] plru_victim(input logic [plru_w-1:0] p);
      logic [way_w-1:0]  v;
      logic [plru_w-1:0] t;
      int                n;
      v = '0;
      t = p;
      n = 0;
      for (int l = 0; l < lvls; l++) begin
         t = p >> n;
         v = (v << 1) | way_w'(t[0]);
         n = 2 * n + 1 + int'(t[0]);
      end
      return v;
   endfunction

   logic [num_way-1:0]      valid_q [num_set];
   logic [num_way-1:0]      valid_d [num_set];
   logic [plru_w-1:0]       plru_q  [num_set];
   logic [plru_w-1:0]       plru_d  [num_set];
   logic [tag_width-1:0]    tag_q   [num_set][num_way];
   logic [tag_width-1:0]    tag_d   [num_set][num_way];
   logic [target_width-1:0] tgt_q   [num_set][num_way];
   logic [target_width-1:0] tgt_d   [num_set][num_way];

   state_t               state_q, state_d;
   logic [bit_set-1:0]   cnt_q, cnt_d;
   logic                 clr_en;

   logic                    arr_hit;
   logic [way_w-1:0]        arr_way;
   logic [target_width-1:0] arr_target;
   logic                    upd_hit, upd_free;
   logic [way_w-1:0]        upd_hit_way, upd_free_way, upd_way;
   logic                    bypass, lkp_touch, upd_fire;

   // ---------------- flush sequencer ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == bit_set'(num_set - 1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      clr_en = 1'b0;
      if (state_q == ST_FLUSH) begin
         busy   = 1'b1;
         clr_en = 1'b1;
      end
   end

   // ---------------- lookup and update way selection ----------------
   always_comb begin
      arr_hit    = 1'b0;
      arr_way    = '0;
      arr_target = '0;
      for (int w = 0; w < num_way; w++) begin
         if (valid_q[lkp_index][w] && (tag_q[lkp_index][w] == lkp_tag)) begin
            arr_hit    = 1'b1;
            arr_way    = way_w'(w);
            arr_target = tgt_q[lkp_index][w];
         end
      end
   end

   // Descending scan so the lowest-index invalid way is the one left selected.
   always_comb begin
      upd_hit      = 1'b0;
      upd_hit_way  = '0;
      upd_free     = 1'b0;
      upd_free_way = '0;
      for (int w = num_way - 1; w >= 0; w--) begin
         if (!valid_q[upd_index][w]) begin
            upd_free     = 1'b1;
            upd_free_way = way_w'(w);
         end
      end
      for (int w = 0; w < num_way; w++) begin
         if (valid_q[upd_index][w] && (tag_q[upd_index][w] == upd_tag)) begin
            upd_hit     = 1'b1;
            upd_hit_way = way_w'(w);
         end
      end
      if (upd_hit) begin
         upd_way = upd_hit_way;
      end else if (upd_free) begin
         upd_way = upd_free_way;
      end else begin
         upd_way = plru_victim(plru_q[upd_index]);
      end
   end

   assign bypass    = upd_valid && (upd_index == lkp_index) && (upd_tag == lkp_tag);
   assign upd_fire  = upd_valid && !busy;
   assign lkp_touch = lkp_en && arr_hit && !bypass && !busy;

   always_comb begin
      lkp_hit    = 1'b0;
      lkp_way    = '0;
      lkp_target = '0;
      if (!busy) begin
         if (bypass) begin
            lkp_hit    = 1'b1;
            lkp_way    = upd_way;
            lkp_target = upd_target;
         end else if (arr_hit) begin
            lkp_hit    = 1'b1;
            lkp_way    = arr_way;
            lkp_target = arr_target;
         end
      end
   end

   // ---------------- array next state ----------------
   // The update touch is applied after the lookup touch so it wins on a shared set.
   always_comb begin
      valid_d = valid_q;
      plru_d  = plru_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      if (lkp_touch) begin
         plru_d[lkp_index] = plru_touch(plru_q[lkp_index], arr_way);
      end
      if (upd_fire) begin
         valid_d[upd_index][upd_way] = 1'b1;
         tag_d[upd_index][upd_way]   = upd_tag;
         tgt_d[upd_index][upd_way]   = upd_target;
         plru_d[upd_index]           = plru_touch(plru_q[upd_index], upd_way);
      end
      if (clr_en) begin
         valid_d[cnt_q] = '0;
         plru_d[cnt_q]  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < num_set; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < num_set; s++) begin
            valid_q[s] <= valid_d[s];
            plru_q[s]  <= plru_d[s];
         end
      end
   end

   // Tags and targets are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
   end

endmodule

// File: tb/tb_btb_sa_array.sv
// Directed bench for btb_sa_array: allocation, PLRU replacement, forwarding,
// flush sequencing and reset abort, checked through an expected-result queue.
module tb_btb_sa_array;

   localparam int W = 34;  // {hit, way, target}

   logic        clk = 1'b0;
   logic        rst;
   logic        lkp_en;
   logic [3:0]  lkp_index;
   logic [23:0] lkp_tag;
   logic        lkp_hit;
   logic [0:0]  lkp_way;
   logic [31:0] lkp_target;
   logic        upd_valid;
   logic [3:0]  upd_index;
   logic [23:0] upd_tag;
   logic [31:0] upd_target;
   logic        flush;
   logic        busy;

   int n_checks = 0;
   int n_err    = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   btb_sa_array dut (
      .clk        (clk),
      .rst        (rst),
      .lkp_en     (lkp_en),
      .lkp_index  (lkp_index),
      .lkp_tag    (lkp_tag),
      .lkp_hit    (lkp_hit),
      .lkp_way    (lkp_way),
      .lkp_target (lkp_target),
      .upd_valid  (upd_valid),
      .upd_index  (upd_index),
      .upd_tag    (upd_tag),
      .upd_target (upd_target),
      .flush      (flush),
      .busy       (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] res(input logic h, input logic w, input logic [31:0] t);
      return {h, w, t};
   endfunction

   task automatic sb_compare(input string tag);
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check(tag, {lkp_hit, lkp_way, lkp_target}, e);
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic uv, input logic [3:0] ui, input logic [23:0] ut,
                        input logic [31:0] utg, input logic le, input logic [3:0] li,
                        input logic [23:0] lt, input bit chk, input logic [W-1:0] exp,
                        input string nm);
      @(negedge clk);
      upd_valid  = uv;
      upd_index  = ui;
      upd_tag    = ut;
      upd_target = utg;
      lkp_en     = le;
      lkp_index  = li;
      lkp_tag    = lt;
      if (chk) begin
         exp_q.push_back(exp);
         #1;
         sb_compare(nm);
      end
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      lkp_en    = 1'b0;
   endtask

   task automatic write(input logic [3:0] i, input logic [23:0] t, input logic [31:0] g);
      drive(1'b1, i, t, g, 1'b0, 4'd0, 24'hFFFFFF, 1'b0, '0, "");
   endtask

   task automatic look(input logic [3:0] i, input logic [23:0] t, input logic en,
                       input logic h, input logic w, input logic [31:0] g, input string nm);
      drive(1'b0, 4'd0, 24'd0, 32'd0, en, i, t, 1'b1, res(h, w, g), nm);
   endtask

   task automatic start_flush();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int busy_cycles;
      int guard;

      rst = 1'b0; lkp_en = 1'b0; lkp_index = 4'd3; lkp_tag = 24'h00ABCD;
      upd_valid = 1'b0; upd_index = '0; upd_tag = '0; upd_target = '0; flush = 1'b0;
      #2;
      check("rst_busy", W'(busy), W'(0));
      exp_q.push_back(res(1'b0, 1'b0, 32'h0));
      sb_compare("rst_lookup");
      @(negedge clk);
      rst = 1'b1;
      look(4'd3, 24'h00ABCD, 1'b1, 1'b0, 1'b0, 32'h0, "post_rst_miss");
      check("idle_busy", W'(busy), W'(0));

      // allocation and in-place target rewrite
      write(4'd5, 24'h12, 32'h8000_0040);
      look(4'd5, 24'h12, 1'b1, 1'b1, 1'b0, 32'h8000_0040, "s5_a_way0");
      write(4'd5, 24'h34, 32'h8000_0044);
      look(4'd5, 24'h34, 1'b1, 1'b1, 1'b1, 32'h8000_0044, "s5_b_way1");
      write(4'd5, 24'h12, 32'h8000_0080);
      look(4'd5, 24'h12, 1'b0, 1'b1, 1'b0, 32'h8000_0080, "s5_a_rewrite");
      look(4'd5, 24'h34, 1'b0, 1'b1, 1'b1, 32'h8000_0044, "s5_b_kept");

      // PLRU: lookup touch with lkp_en high protects way 0
      write(4'd7, 24'h0A, 32'h0000_A000);
      write(4'd7, 24'h0B, 32'h0000_B000);
      look(4'd7, 24'h0A, 1'b1, 1'b1, 1'b0, 32'h0000_A000, "s7_a_touch");
      write(4'd7, 24'h0C, 32'h0000_C000);
      look(4'd7, 24'h0B, 1'b0, 1'b0, 1'b0, 32'h0, "s7_b_evicted");
      look(4'd7, 24'h0A, 1'b0, 1'b1, 1'b0, 32'h0000_A000, "s7_a_kept");
      look(4'd7, 24'h0C, 1'b0, 1'b1, 1'b1, 32'h0000_C000, "s7_c_way1");

      // PLRU: lookup with lkp_en low leaves way 0 as victim
      write(4'd8, 24'h0A, 32'h0001_A000);
      write(4'd8, 24'h0B, 32'h0001_B000);
      look(4'd8, 24'h0A, 1'b0, 1'b1, 1'b0, 32'h0001_A000, "s8_a_notouch");
      write(4'd8, 24'h0C, 32'h0001_C000);
      look(4'd8, 24'h0A, 1'b0, 1'b0, 1'b0, 32'h0, "s8_a_evicted");
      look(4'd8, 24'h0B, 1'b0, 1'b1, 1'b1, 32'h0001_B000, "s8_b_kept");
      look(4'd8, 24'h0C, 1'b0, 1'b1, 1'b0, 32'h0001_C000, "s8_c_way0");

      // same-cycle forwarding
      drive(1'b1, 4'd2, 24'h55, 32'hDEAD_BEEC, 1'b1, 4'd2, 24'h55, 1'b1,
            res(1'b1, 1'b0, 32'hDEAD_BEEC), "bypass");
      look(4'd2, 24'h55, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEC, "bypass_written");

      // flush: exact duration, ignored update and second pulse
      start_flush();
      busy_cycles = 0;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 40) begin
         busy_cycles++;
         if (busy_cycles == 4) begin
            upd_valid = 1'b1; upd_index = 4'd9; upd_tag = 24'h99; upd_target = 32'h9999_0000;
            lkp_en = 1'b1; lkp_index = 4'd9; lkp_tag = 24'h99;
            exp_q.push_back(res(1'b0, 1'b0, 32'h0));
            #1;
            sb_compare("busy_bypass_blocked");
         end
         if (busy_cycles == 6) flush = 1'b1;
         @(posedge clk);
         #1;
         upd_valid = 1'b0; lkp_en = 1'b0; flush = 1'b0;
         guard++;
         @(negedge clk);
      end
      check("flush_len", W'(busy_cycles), W'(16));
      lkp_en = 1'b1; lkp_index = 4'd5; lkp_tag = 24'h12;
      exp_q.push_back(res(1'b0, 1'b0, 32'h0));
      #1;
      sb_compare("first_after_flush");
      @(posedge clk);
      #1;
      lkp_en = 1'b0;
      look(4'd5, 24'h34, 1'b0, 1'b0, 1'b0, 32'h0, "flushed_s5_b");
      look(4'd7, 24'h0A, 1'b0, 1'b0, 1'b0, 32'h0, "flushed_s7_a");
      look(4'd7, 24'h0C, 1'b0, 1'b0, 1'b0, 32'h0, "flushed_s7_c");
      look(4'd8, 24'h0B, 1'b0, 1'b0, 1'b0, 32'h0, "flushed_s8_b");
      look(4'd2, 24'h55, 1'b0, 1'b0, 1'b0, 32'h0, "flushed_s2");
      look(4'd9, 24'h99, 1'b0, 1'b0, 1'b0, 32'h0, "dropped_update");
      check("busy_after_flush", W'(busy), W'(0));

      // post-flush allocation starts from a clean PLRU state
      write(4'd7, 24'h0D, 32'h0000_D000);
      look(4'd7, 24'h0D, 1'b0, 1'b1, 1'b0, 32'h0000_D000, "post_flush_alloc");

      // reset in the middle of a flush
      write(4'd12, 24'hC12, 32'h0000_1200);
      write(4'd14, 24'hE14, 32'h0000_1400);
      look(4'd12, 24'hC12, 1'b0, 1'b1, 1'b0, 32'h0000_1200, "s12_before");
      start_flush();
      repeat (6) @(posedge clk);
      #2;
      check("busy_mid_flush", W'(busy), W'(1));
      lkp_index = 4'd12; lkp_tag = 24'hC12;
      rst = 1'b0;
      #1;
      check("busy_rst_abort", W'(busy), W'(0));
      exp_q.push_back(res(1'b0, 1'b0, 32'h0));
      sb_compare("rst_abort_lookup");
      @(negedge clk);
      rst = 1'b1;
      look(4'd12, 24'hC12, 1'b0, 1'b0, 1'b0, 32'h0, "s12_after_rst");
      look(4'd14, 24'hE14, 1'b0, 1'b0, 1'b0, 32'h0, "s14_after_rst");
      check("busy_after_rst", W'(busy), W'(0));
      write(4'd4, 24'h42, 32'hCAFE_0000);
      look(4'd4, 24'h42, 1'b1, 1'b1, 1'b0, 32'hCAFE_0000, "s4_after_rst");
      write(4'd4, 24'h43, 32'hCAFE_0004);
      look(4'd4, 24'h43, 1'b1, 1'b1, 1'b1, 32'hCAFE_0004, "s4_way1_after_rst");

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
